// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } rr_state_e;

   // Explicit wrap so non-power-of-two widths never land on an unused index.
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned width);
      return (v + 1 == width) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first unmasked request scanning upward from i_ptr with wrap.
module rr_pick #(
   parameter  int unsigned WIDTH     = 16,
   localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]     i_req,
   input  logic [WIDTH_LOG-1:0] i_ptr,
   input  logic [WIDTH-1:0]     i_mask,
   output logic [WIDTH-1:0]     o_pick,
   output logic [WIDTH_LOG-1:0] o_idx,
   output logic                 o_any
);

   localparam logic [WIDTH_LOG:0] W_EXT = (WIDTH_LOG + 1)'(WIDTH);

   logic [WIDTH-1:0] w_req;
   assign w_req = i_req & ~i_mask;

   always_comb begin
      logic [WIDTH_LOG:0] w_pos;
      o_pick = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_pos  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         // ptr < WIDTH and i < WIDTH, so a single subtraction is enough to wrap.
         w_pos = {1'b0, i_ptr} + (WIDTH_LOG + 1)'(i);
         if (w_pos >= W_EXT) w_pos = w_pos - W_EXT;
         if (!o_any && w_req[w_pos[WIDTH_LOG-1:0]]) begin
            o_pick[w_pos[WIDTH_LOG-1:0]] = 1'b1;
            o_idx                        = w_pos[WIDTH_LOG-1:0];
            o_any                        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until the consumer accepts it.
module rr_grant_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter  int unsigned WIDTH     = 16,
   localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [WIDTH-1:0]     i_req,
   output logic [WIDTH-1:0]     o_gnt,
   output logic                 o_gnt_vld,
   input  logic                 i_gnt_rdy,
   output logic [WIDTH_LOG-1:0] o_ptr
);

   rr_state_e            r_state, w_state_d;
   logic [WIDTH-1:0]     r_gnt, w_gnt_d;
   logic [WIDTH_LOG-1:0] r_idx, w_idx_d;
   logic [WIDTH_LOG-1:0] r_ptr, w_ptr_d;

   logic                 w_xfer;
   logic [WIDTH_LOG-1:0] w_ptr_inc;
   logic [WIDTH_LOG-1:0] w_pick_ptr;
   logic [WIDTH-1:0]     w_mask;
   logic [WIDTH-1:0]     w_pick;
   logic [WIDTH_LOG-1:0] w_pick_idx;
   logic                 w_pick_any;

   assign w_xfer    = (r_state == GRANT) && i_gnt_rdy;
   assign w_ptr_inc = WIDTH_LOG'(wrap_inc(32'(r_idx), WIDTH));

   // On a transfer, re-arbitrate from the rotated pointer with the served requester excluded.
   assign w_pick_ptr = w_xfer ? w_ptr_inc : r_ptr;
   assign w_mask     = w_xfer ? r_gnt : '0;

   rr_pick #(
      .WIDTH (WIDTH)
   ) u_pick (
      .i_req  (i_req),
      .i_ptr  (w_pick_ptr),
      .i_mask (w_mask),
      .o_pick (w_pick),
      .o_idx  (w_pick_idx),
      .o_any  (w_pick_any)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_d;
         r_gnt   <= w_gnt_d;
         r_idx   <= w_idx_d;
         r_ptr   <= w_ptr_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_gnt_d   = r_gnt;
      w_idx_d   = r_idx;
      w_ptr_d   = r_ptr;
      unique case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_d = GRANT;
               w_gnt_d   = w_pick;
               w_idx_d   = w_pick_idx;
            end
         end
         GRANT: begin
            if (w_xfer) begin
               w_ptr_d = w_ptr_inc;
               if (w_pick_any) begin
                  w_gnt_d = w_pick;
                  w_idx_d = w_pick_idx;
               end else begin
                  w_state_d = IDLE;
                  w_gnt_d   = '0;
               end
            end
         end
         default: begin
            w_state_d = IDLE;
            w_gnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      o_gnt_vld = (r_state == GRANT);
      o_gnt     = r_gnt;
      o_ptr     = r_ptr;
   end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed self-checking bench for rr_grant_arbiter at WIDTH=16.
module tb_rr_grant_arbiter;

   localparam int unsigned WIDTH = 16;

   logic        clk;
   logic        rst;
   logic [15:0] req;
   logic [15:0] gnt;
   logic        gnt_vld;
   logic        gnt_rdy;
   logic [3:0]  ptr;

   int n_checks;
   int n_errors;

   rr_grant_arbiter #(
      .WIDTH (WIDTH)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_req     (req),
      .o_gnt     (gnt),
      .o_gnt_vld (gnt_vld),
      .i_gnt_rdy (gnt_rdy),
      .o_ptr     (ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle; inputs changed after this apply to the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req     = 16'h0000;
      gnt_rdy = 1'b0;
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || ptr !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_idle cyc %0d: gnt=%h vld=%b ptr=%0d, want gnt=0000 vld=0 ptr=0",
                     c, gnt, gnt_vld, ptr);
         end
         step();
      end
   endtask

   task automatic test_single();
      req     = 16'h0000;
      gnt_rdy = 1'b1;
      apply_reset();
      req = 16'h0010;
      step();
      n_checks++;
      if (gnt !== 16'h0010 || gnt_vld !== 1'b1 || ptr !== 4'd0) begin
         n_errors++;
         $display("FAIL single_first: gnt=%h vld=%b ptr=%0d, want gnt=0010 vld=1 ptr=0",
                  gnt, gnt_vld, ptr);
      end
      step();
      n_checks++;
      if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || ptr !== 4'd5) begin
         n_errors++;
         $display("FAIL single_bubble: gnt=%h vld=%b ptr=%0d, want gnt=0000 vld=0 ptr=5",
                  gnt, gnt_vld, ptr);
      end
      step();
      n_checks++;
      if (gnt !== 16'h0010 || gnt_vld !== 1'b1 || ptr !== 4'd5) begin
         n_errors++;
         $display("FAIL single_regrant: gnt=%h vld=%b ptr=%0d, want gnt=0010 vld=1 ptr=5",
                  gnt, gnt_vld, ptr);
      end
      req     = 16'h0000;
      gnt_rdy = 1'b0;
   endtask

   task automatic test_rotation();
      logic [15:0] exp_gnt;
      logic [3:0]  exp_ptr;
      req     = 16'h0000;
      gnt_rdy = 1'b1;
      apply_reset();
      req = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         step();
         exp_gnt = 16'h0001 << (i % 16);
         exp_ptr = 4'(i % 16);
         n_checks++;
         if (gnt !== exp_gnt || gnt_vld !== 1'b1 || ptr !== exp_ptr) begin
            n_errors++;
            $display("FAIL rotation %0d: gnt=%h vld=%b ptr=%0d, want gnt=%h vld=1 ptr=%0d",
                     i, gnt, gnt_vld, ptr, exp_gnt, exp_ptr);
         end
         n_checks++;
         if (!$onehot0(gnt) || (gnt_vld !== (|gnt))) begin
            n_errors++;
            $display("FAIL rotation_invariant %0d: gnt=%h vld=%b, want onehot0 and vld==|gnt",
                     i, gnt, gnt_vld);
         end
      end
      req     = 16'h0000;
      gnt_rdy = 1'b0;
   endtask

   task automatic test_backpressure();
      req     = 16'h0000;
      gnt_rdy = 1'b0;
      apply_reset();
      req = 16'h0081;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++;
         if (gnt !== 16'h0001 || gnt_vld !== 1'b1 || ptr !== 4'd0) begin
            n_errors++;
            $display("FAIL hold %0d: gnt=%h vld=%b ptr=%0d, want gnt=0001 vld=1 ptr=0",
                     c, gnt, gnt_vld, ptr);
         end
      end
      req = 16'h0080;
      step();
      n_checks++;
      if (gnt !== 16'h0001 || gnt_vld !== 1'b1) begin
         n_errors++;
         $display("FAIL hold_req_drop: gnt=%h vld=%b, want gnt=0001 vld=1", gnt, gnt_vld);
      end
      gnt_rdy = 1'b1;
      step();
      n_checks++;
      if (gnt !== 16'h0080 || gnt_vld !== 1'b1 || ptr !== 4'd1) begin
         n_errors++;
         $display("FAIL hold_release: gnt=%h vld=%b ptr=%0d, want gnt=0080 vld=1 ptr=1",
                  gnt, gnt_vld, ptr);
      end
      req     = 16'h0000;
      gnt_rdy = 1'b0;
   endtask

   task automatic test_wrap_sparse();
      req     = 16'h0000;
      gnt_rdy = 1'b0;
      apply_reset();
      req = 16'h2000;
      step();
      n_checks++;
      if (gnt !== 16'h2000 || gnt_vld !== 1'b1) begin
         n_errors++;
         $display("FAIL wrap_setup: gnt=%h vld=%b, want gnt=2000 vld=1", gnt, gnt_vld);
      end
      // Serving 13 moves ptr to 14; the scan 14,15,0,1,2 must reach bit 2 before 13.
      req     = 16'h2004;
      gnt_rdy = 1'b1;
      step();
      n_checks++;
      if (gnt !== 16'h0004 || gnt_vld !== 1'b1 || ptr !== 4'd14) begin
         n_errors++;
         $display("FAIL wrap_pick: gnt=%h vld=%b ptr=%0d, want gnt=0004 vld=1 ptr=14",
                  gnt, gnt_vld, ptr);
      end
      step();
      n_checks++;
      if (gnt !== 16'h2000 || gnt_vld !== 1'b1 || ptr !== 4'd3) begin
         n_errors++;
         $display("FAIL wrap_after: gnt=%h vld=%b ptr=%0d, want gnt=2000 vld=1 ptr=3",
                  gnt, gnt_vld, ptr);
      end
      req     = 16'h0000;
      gnt_rdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      req     = 16'h0000;
      gnt_rdy = 1'b1;
      apply_reset();
      req = 16'h8001;
      step();
      step();
      gnt_rdy = 1'b0;
      step();
      n_checks++;
      if (gnt_vld !== 1'b1 || ptr === 4'd0) begin
         n_errors++;
         $display("FAIL mid_setup: vld=%b ptr=%0d, want vld=1 ptr!=0", gnt_vld, ptr);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || ptr !== 4'd0) begin
         n_errors++;
         $display("FAIL mid_reset: gnt=%h vld=%b ptr=%0d, want gnt=0000 vld=0 ptr=0",
                  gnt, gnt_vld, ptr);
      end
      step();
      n_checks++;
      if (gnt !== 16'h0001 || gnt_vld !== 1'b1 || ptr !== 4'd0) begin
         n_errors++;
         $display("FAIL mid_regrant: gnt=%h vld=%b ptr=%0d, want gnt=0001 vld=1 ptr=0",
                  gnt, gnt_vld, ptr);
      end
      req = 16'h0000;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      req      = 16'h0000;
      gnt_rdy  = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_wrap_sparse();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
Round-robin arbiter producing a registered one-hot grant vector with a valid/ready handshake.
It sits directly upstream of onehot_encoder_tree: its gnt output drives the encoder's dec_vld, and gnt_vld qualifies it.
The grant is held stable until the consumer accepts it, then priority rotates past the served requester.

Parameters:
WIDTH, 16, number of requesters, ≥2, need not be a power of two
WIDTH_LOG, $clog2(WIDTH), pointer width (localparam)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
req  input  WIDTH  level request per requester
gnt  output  WIDTH  registered one-hot grant; all-zero when gnt_vld=0
gnt_vld  output  1  grant valid
gnt_rdy  input  1  consumer accepts grant; transfer = gnt_vld & gnt_rdy
ptr  output  WIDTH_LOG  current highest-priority index (debug/observability)

Behaviour:
- Reset (rst=1 at edge): gnt='0, gnt_vld=0, ptr=0. Reset overrides any in-flight grant, including one mid-handshake; that grant is dropped without transfer.
- Two states: IDLE (gnt_vld=0) and GRANT (gnt_vld=1).
- Arbitration: combinational pick = first set req bit scanning ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1.
- IDLE: if |req, next edge -> GRANT with gnt=pick and gnt_vld=1 (latency 1 cycle from req to gnt_vld). Otherwise stay IDLE, outputs zero.
- GRANT, no transfer: gnt, gnt_vld and ptr hold unchanged, even if req[k] deasserts.
- Request stability is the requester's contract; the arbiter never withdraws an offered grant.
- GRANT, transfer on granted index k:
  - ptr <= (k+1==WIDTH) ? 0 : k+1, with explicit wrap (non-power-of-two safe).
  - Same cycle, arbitrate again over req with k masked out, using the new pointer value (k+1).
  - If any other request exists, next edge stays in GRANT with the new grant (back-to-back, no bubble).
  - Else -> IDLE, gnt='0.
- A requester just served is not re-granted back-to-back while any other request is pending. If it is the only requester, it is re-granted after one idle cycle (bubble).
- gnt_rdy while gnt_vld=0: ignored.
- Invariants: $onehot0(gnt); gnt_vld == |gnt.

Decomposition:
- Package rr_arbiter_pkg: function for wrap-increment of ptr; a typedef for state enum {IDLE, GRANT}.
- Sub-module rr_pick (combinational): req, ptr, mask -> one-hot pick. Implemented as a double-width vector search or a rotate-priority-rotate.
- The rest is the state register and handshake in rr_grant_arbiter.

Test Plan:
- Reset/idle (WIDTH=16): rst then req=0 for 5 cycles -> gnt=0, gnt_vld=0, ptr=0 throughout.
- Single request: req=16'h0010, gnt_rdy=1 -> gnt_vld=1 next cycle with gnt=16'h0010. After transfer ptr=5. Next grant comes after 1 bubble; a downstream encoder shows enc_idx=4.
- Rotation fairness: req=16'hFFFF, gnt_rdy=1 for 32 cycles -> grants 0,1,…,15,0,1,… one per cycle with no bubbles; ptr wraps 15->0.
- Backpressure hold: req=16'h0081, gnt_rdy=0 for 4 cycles -> gnt=16'h0001 stable. Drop req[0] during the hold -> gnt unchanged. Raise gnt_rdy -> next gnt=16'h0080, ptr=1.
- Wrap with sparse requests: ptr=14 (after serving 13), req=16'h2004 -> gnt=16'h0004, not 13. Then ptr=3.
- Reset mid-operation: gnt_vld=1, gnt_rdy=0, assert rst for 1 cycle -> next cycle gnt=0, gnt_vld=0, ptr=0. With req=16'h8001 held, gnt=16'h0001 one cycle after rst deasserts.
